// File: rtl/lane_counter_if.sv
// lane_counter_if -- lane detector / count bus for lane_counter.
//   carIn     [7:0]       arrival detector levels, bit order N1,N2,E1,E2,S1,S2,W1,W2
//   carOut    [7:0]       departure detector levels, same bit order
//   laneGreen [7:0]       per-lane light state, 1 = green
//   lane      [7:0][7:0]  per-lane car count (lane[i] pairs with bit i)
//   ovf       [7:0]       sticky per-lane saturation-drop flags
//   total     [10:0]      sum of all lane outputs
//   sample                snapshot strobe (only with LANE_COUNT_SNAPSHOT_EN)
// master = stimulus side (drives detectors), slave = lane_counter.
interface lane_counter_if;
  logic [7:0]      carIn;
  logic [7:0]      carOut;
  logic [7:0]      laneGreen;
  logic [7:0][7:0] lane;
  logic [7:0]      ovf;
  logic [10:0]     total;
`ifdef LANE_COUNT_SNAPSHOT_EN
  logic            sample;

  modport master (output carIn, carOut, laneGreen, sample,
                  input  lane, ovf, total);
  modport slave  (input  carIn, carOut, laneGreen, sample,
                  output lane, ovf, total);
`else
  modport master (output carIn, carOut, laneGreen,
                  input  lane, ovf, total);
  modport slave  (input  carIn, carOut, laneGreen,
                  output lane, ovf, total);
`endif
endinterface

// File: rtl/lane_counter.sv
// lane_counter -- eight independent saturating car counters driven by
// edge-detected arrival/departure detector levels.
// Ports:
//   clk   : single clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : lane_counter_if.slave (carIn, carOut, laneGreen in;
//           lane, ovf, total out; sample in when snapshot build)
// Parameter SAT_LIMIT (1..255): per-lane count saturation value.
// Optional macro LANE_COUNT_SNAPSHOT_EN: adds the sample strobe and a
// snapshot register; lane/total then show the last sampled counts.
module lane_counter #(
  parameter logic [7:0] SAT_LIMIT = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  lane_counter_if.slave bus
);

  logic [7:0]      carin_prev_q, carin_prev_d;
  logic [7:0]      carout_prev_q, carout_prev_d;
  logic [7:0][7:0] count_q, count_d;
  logic [7:0]      ovf_q, ovf_d;
  logic [7:0]      arr_s;
  logic [7:0]      dep_s;
  logic [7:0][7:0] lane_s;
  logic [10:0]     total_s;

  // Rising-edge events; a departure only counts while its lane is green.
  always_comb begin
    arr_s = bus.carIn & ~carin_prev_q;
    dep_s = bus.carOut & ~carout_prev_q & bus.laneGreen;
    carin_prev_d  = bus.carIn;
    carout_prev_d = bus.carOut;
  end

  // Per-lane count update: a paired arrival+departure nets to zero even at
  // 0 or SAT_LIMIT; lone events are clipped at the bounds.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < 8; i++) begin
      case ({arr_s[i], dep_s[i]})
        2'b10: begin
          if (count_q[i] == SAT_LIMIT) begin
            ovf_d[i] = 1'b1;
          end else begin
            count_d[i] = count_q[i] + 8'd1;
          end
        end
        2'b01: begin
          if (count_q[i] != 8'd0) begin
            count_d[i] = count_q[i] - 8'd1;
          end else begin
            count_d[i] = count_q[i];
          end
        end
        2'b11:   count_d[i] = count_q[i];
        2'b00:   count_d[i] = count_q[i];
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // Edge detectors reset to ones so a level held through reset is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      carin_prev_q  <= 8'hFF;
      carout_prev_q <= 8'hFF;
      count_q       <= '0;
      ovf_q         <= 8'h00;
    end else begin
      carin_prev_q  <= carin_prev_d;
      carout_prev_q <= carout_prev_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
    end
  end

`ifdef LANE_COUNT_SNAPSHOT_EN
  logic [7:0][7:0] snap_q, snap_d;

  // Snapshot captures the post-update counts on a sample edge.
  always_comb begin
    if (bus.sample) begin
      snap_d = count_d;
    end else begin
      snap_d = snap_q;
    end
  end

  // Snapshot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign lane_s = snap_q;
`else
  assign lane_s = count_q;
`endif

  // Combinational sum of the visible lane outputs; 11 bits cannot overflow.
  always_comb begin
    total_s = 11'd0;
    for (int i = 0; i < 8; i++) begin
      total_s = total_s + {3'b000, lane_s[i]};
    end
  end

  assign bus.lane  = lane_s;
  assign bus.ovf   = ovf_q;
  assign bus.total = total_s;

endmodule
